ram_bank: RTL

RAM_BANK -- requirements
Module: ram_bank

---
 rtl/ram_bank.sv | 94 +++++++++
 1 files changed

// File: rtl/ram_bank.sv
// Simple dual-port byte-enabled RAM bank that zero-sweeps every word after reset.
// Define RAM_BANK_WR_BYPASS_EN to forward same-address write data onto the read port.
module ram_bank #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [DATA_W/8-1:0]   i_be,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_W-1:0]     o_data,
  output logic                  o_valid,
  output logic                  o_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned BYTES = DATA_W / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   wr_word;
  logic [DATA_W-1:0]   rd_word;

  // Old word with the enabled bytes replaced by the incoming data.
  always_comb begin
    wr_word = mem[i_waddr];
    for (int unsigned k = 0; k < BYTES; k++) begin
      if (i_be[k]) wr_word[8*k +: 8] = i_data[8*k +: 8];
    end
  end

`ifdef RAM_BANK_WR_BYPASS_EN
  assign rd_word = (i_we && (i_raddr == i_waddr)) ? wr_word : mem[i_raddr];
`else
  assign rd_word = mem[i_raddr];
`endif

  // Storage: the clear sweep owns the write port while busy.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else if (i_we) begin
        mem[i_waddr] <= wr_word;
      end
    end
  end

  // Sweep FSM and registered read port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= CLEAR;
      cnt     <= '0;
      o_busy  <= 1'b1;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        CLEAR: begin
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state  <= READY;
            o_busy <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        READY: begin
          o_busy <= 1'b0;
          if (i_re) begin
            o_valid <= 1'b1;
            o_data  <= rd_word;
          end
        end
        default: begin
          state  <= CLEAR;
          cnt    <= '0;
          o_busy <= 1'b1;
        end
      endcase
    end
  end

endmodule
